// File: rtl/mdu_unit_if.sv
// rtl/mdu_unit_if.sv - Operand/command/result bundle between EX stage and the multiply/divide unit
//
// Purpose: groups the MDU command inputs and the HI/LO/BUSY/DONE outputs.
// Signals:
//   A, B    : 32-bit operands (dividend/multiplicand/mthi-mtlo data, divisor/multiplier)
//   MDU_OP  : 3-bit op (0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op)
//   START   : qualifies MDU_OP for one cycle
//   BUSY    : operation in flight
//   DONE    : one-cycle pulse when a mult/div commits HI/LO
//   HI, LO  : architectural HI/LO registers
// Modports: master drives the command, slave is the unit itself.
interface mdu_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDU_OP;
  logic        START;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output A, B, MDU_OP, START,
    input  BUSY, DONE, HI, LO
  );

  modport slave (
    input  A, B, MDU_OP, START,
    output BUSY, DONE, HI, LO
  );
endinterface

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - Multi-cycle multiply/divide unit with architectural HI/LO
//
// Purpose: executes mult/multu/div/divu into HI/LO after a fixed busy window,
// and handles mthi/mtlo writes in a single cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mdu_unit_if.slave (A, B, MDU_OP, START in; BUSY, DONE, HI, LO out)
// Parameters:
//   MULT_CYCLES : busy duration of mult/multu (1..15)
//   DIV_CYCLES  : busy duration of div/divu (1..15)
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic         clk,
  input logic         rst_n,
  mdu_unit_if.slave   bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, finish;
  logic        busy_q, done_q;
  logic [31:0] hi_q, lo_q;
  logic [63:0] res_q;
  logic        div0_q;

  // Op decode: bit2 clear = mult/div; bit1 selects divide; bit0 clear = signed.
  logic is_muldiv, is_div, is_signed, is_mthi, is_mtlo;
  assign is_muldiv = ~bus.MDU_OP[2];
  assign is_div    = bus.MDU_OP[1];
  assign is_signed = ~bus.MDU_OP[0];
  assign is_mthi   = (bus.MDU_OP == 3'd4);
  assign is_mtlo   = (bus.MDU_OP == 3'd5);

  // One multiplier serves both flavours: the low 64 bits of the product of
  // sign- or zero-extended operands equal the signed or unsigned product.
  logic [63:0] ext_a, ext_b, product;
  assign ext_a   = {{32{is_signed & bus.A[31]}}, bus.A};
  assign ext_b   = {{32{is_signed & bus.B[31]}}, bus.B};
  assign product = ext_a * ext_b;

  // One unsigned divider on operand magnitudes; signs are restored afterwards.
  // Quotient truncates toward zero and the remainder follows the dividend,
  // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  logic        neg_a, neg_b, div0;
  logic [31:0] num, den, den_safe, q_mag, r_mag, quot, rem;
  assign neg_a    = is_signed & bus.A[31];
  assign neg_b    = is_signed & bus.B[31];
  assign num      = neg_a ? -bus.A : bus.A;
  assign den      = neg_b ? -bus.B : bus.B;
  assign div0     = (bus.B == 32'd0);
  assign den_safe = div0 ? 32'd1 : den;
  assign q_mag    = num / den_safe;
  assign r_mag    = num % den_safe;
  assign quot     = (neg_a ^ neg_b) ? -q_mag : q_mag;
  assign rem      = neg_a ? -r_mag : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.START && is_muldiv) begin
          accept  = 1'b1;
          cnt_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      res_q   <= 64'd0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (cnt_d != 4'd0);
      done_q  <= finish;
      if (accept) begin
        res_q  <= is_div ? {rem, quot} : product;
        div0_q <= is_div & div0;
      end
      if (finish && !div0_q) begin
        hi_q <= res_q[63:32];
        lo_q <= res_q[31:0];
      end
      // mthi/mtlo only land while idle; during a run START is ignored.
      if (state_q == S_IDLE && bus.START) begin
        if (is_mthi) hi_q <= bus.A;
        if (is_mtlo) lo_q <= bus.A;
      end
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - Directed self-checking bench for mdu_unit
module tb_mdu_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mdu_unit_if bus ();

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents the command for exactly one rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.MDU_OP = op;
    bus.A      = a;
    bus.B      = b;
    bus.START  = 1'b1;
    @(negedge clk);
    bus.START  = 1'b0;
  endtask

  // Issues a mult/div, counts BUSY cycles and DONE pulses, checks HI/LO.
  // With tail set, also checks that DONE is low one cycle later.
  task automatic op_wait(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cycles,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit tail);
    int n;
    int dn;
    n  = 0;
    dn = 0;
    issue(op, a, b);
    while (bus.BUSY && n < 40) begin
      n++;
      @(negedge clk);
      if (bus.DONE) dn++;
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    check({tag, "_done_cnt"}, 32'(dn), 32'd1);
    check({tag, "_hi"}, bus.HI, exp_hi);
    check({tag, "_lo"}, bus.LO, exp_lo);
    if (tail) begin
      @(negedge clk);
      check({tag, "_done_low"}, 32'(bus.DONE), 32'd0);
    end
  endtask

  initial begin
    int dn;
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    bus.MDU_OP = 3'd7;
    bus.START  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op_wait("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
    op_wait("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, 1'b1);
    op_wait("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    op_wait("divu", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b1);

    issue(3'd4, 32'h12345678, 32'd0);
    check("mthi_busy", 32'(bus.BUSY), 32'd0);
    check("mthi_done", 32'(bus.DONE), 32'd0);
    check("mthi_hi", bus.HI, 32'h12345678);
    check("mthi_lo", bus.LO, 32'd3);

    op_wait("div0", 3'd2, 32'd100, 32'd0, 10, 32'h12345678, 32'd3, 1'b1);
    op_wait("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 1'b1);

    issue(3'd6, 32'h55555555, 32'd9);
    check("nop_busy", 32'(bus.BUSY), 32'd0);
    check("nop_hi", bus.HI, 32'd0);
    check("nop_lo", bus.LO, 32'h80000000);

    // multu at edge T, mtlo sampled at T+2 and div at T+3 must be ignored.
    issue(3'd1, 32'h00010000, 32'h00030000);
    @(negedge clk);
    bus.MDU_OP = 3'd5; bus.A = 32'h0000DEAD; bus.START = 1'b1;
    @(negedge clk);
    bus.MDU_OP = 3'd2; bus.A = 32'd50; bus.B = 32'd7;
    @(negedge clk);
    bus.START = 1'b0;
    check("ign_busy_t3", 32'(bus.BUSY), 32'd1);
    check("ign_lo_t3", bus.LO, 32'h80000000);
    @(negedge clk);
    check("ign_busy_t4", 32'(bus.BUSY), 32'd1);
    @(negedge clk);
    check("ign_busy_t5", 32'(bus.BUSY), 32'd0);
    check("ign_done_t5", 32'(bus.DONE), 32'd1);
    check("ign_hi", bus.HI, 32'd3);
    check("ign_lo", bus.LO, 32'd0);
    @(negedge clk);
    check("ign_after_busy", 32'(bus.BUSY), 32'd0);
    check("ign_after_lo", bus.LO, 32'd0);

    // Abort a divide with an asynchronous reset mid-flight.
    issue(3'd3, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.BUSY), 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.DONE) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    check("abort_hi_after", bus.HI, 32'd0);
    check("abort_lo_after", bus.LO, 32'd0);

    // Back-to-back: second mult issued in the cycle BUSY falls.
    op_wait("b2b1", 3'd0, 32'd5, 32'hFFFFFFFD, 5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    op_wait("b2b2", 3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 5, 32'h3FFFFFFF, 32'h00000001, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit; sits in the EX stage beside the single-cycle ALU and takes the same A/B operands from the forwarding muxes.
- Executes mult/multu/div/divu into architectural HI/LO registers and handles mthi/mtlo writes.
- Exposes BUSY for the hazard unit's stall logic and HI/LO for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles; legal range 1..15.
- DIV_CYCLES, 10, busy duration of div/divu in cycles; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  32  rs operand; dividend / multiplicand / mthi-mtlo data
- B  input  32  rt operand; divisor / multiplier
- MDU_OP  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
- START  input  1  qualifies MDU_OP for one cycle
- BUSY  output  1  operation in flight
- DONE  output  1  one-cycle pulse when HI/LO are committed by mult/div
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset: async on rst_n low. HI=0, LO=0, BUSY=0, DONE=0, counter=0, latched results=0. Reset mid-operation aborts it; no HI/LO update after release.
- Idle (BUSY=0), START=1, op 0-3 at edge T:
  - Compute the 64-bit result from A/B at that edge and hold it in internal registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- BUSY = (counter != 0), registered. High for exactly N cycles after edge T.
- At edge T+N: counter reaches 0, HI/LO take the held result, DONE=1 for that cycle only. BUSY=0 in the same cycle.
- mult: {HI,LO} = signed(A)*signed(B), 64-bit. multu: unsigned product.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (A).
- divu: unsigned quotient in LO, remainder in HI.
- Signed overflow: 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0, div or divu):
  - Unit still goes BUSY for DIV_CYCLES.
  - HI/LO are left unchanged at completion. DONE still pulses.
- mthi / mtlo with START=1 and BUSY=0: HI (resp. LO) <= A at that edge. BUSY stays 0, no DONE.
- START while BUSY=1: ignored, any op. The hazard unit must stall; the block does not queue.
- START with op 6-7: no effect.
- Outputs are registers only; no combinational path from inputs to outputs.

Test Plan:
- Reset, then mult A=0xFFFFFFFE(-2), B=3 at edge T -> BUSY high cycles T+1..T+5; at T+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA, DONE pulse. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9(-7), B=2 -> after 10 BUSY cycles LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). divu A=7, B=2 -> LO=3, HI=1.
- mthi A=0x12345678, then div with B=0 -> BUSY 10 cycles, DONE pulses, HI stays 0x12345678, LO unchanged. div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start multu, then pulse START with mtlo A=0xDEAD and later div at cycles T+2 and T+3 -> both ignored; final result equals the multu result, BUSY drops exactly at T+5.
- Start div, drop rst_n at T+4 -> HI=LO=0 and BUSY=0 immediately (async). After release, no DONE pulse and HI/LO stay 0.
- Back-to-back ops: mult issued in the cycle BUSY falls -> accepted; second BUSY window of 5 cycles. DONE pulses once per operation.
